// File: rtl/synapse_driver.sv
`default_nettype none
// ============================================================================
//  Module   : synapse_driver
//  Purpose  : Presynaptic front end for one LIF neuron. Latches spike pulses
//             into a pending mask, looks up a per-line programmable weight and
//             serialises pending events round-robin onto a registered
//             current/valid/ready output stream, one event per cycle.
//  Options  : SYN_DROP_CNT_EN - adds an 8-bit saturating drop_count output
//             that counts spikes merged into an already-pending line.
//  Revision : 1.0 - initial release
// ============================================================================
module synapse_driver #(
    parameter int                      N_INPUTS       = 4,
    parameter int                      ADDR_WIDTH     = 2,
    parameter int                      WEIGHT_WIDTH   = 8,
    parameter logic [WEIGHT_WIDTH-1:0] DEFAULT_WEIGHT = 8'h10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_INPUTS-1:0]     spike_in,
    input  logic                    w_we,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    output logic [WEIGHT_WIDTH-1:0] out_current,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_src,
    output logic [N_INPUTS-1:0]     pending_out
`ifdef SYN_DROP_CNT_EN
    ,
    output logic [7:0]              drop_count
`endif
);

    logic [WEIGHT_WIDTH-1:0] r_weight [N_INPUTS];
    logic [N_INPUTS-1:0]     r_pending;
    logic [ADDR_WIDTH-1:0]   r_rr_ptr;
    logic                    r_out_valid;
    logic [WEIGHT_WIDTH-1:0] r_out_current;
    logic [ADDR_WIDTH-1:0]   r_out_src;

    logic                    w_found;
    logic [ADDR_WIDTH-1:0]   w_winner;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_load;
    logic [N_INPUTS-1:0]     w_clear;
    logic [N_INPUTS-1:0]     w_spike_acc;

    // Per-line weight registers; writes are independent of enable
    for (genvar k = 0; k < N_INPUTS; k++) begin : g_weight
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_weight[k] <= DEFAULT_WEIGHT;
            end else if (w_we && (w_addr == ADDR_WIDTH'(k))) begin
                r_weight[k] <= w_data;
            end
        end
    end

    // Round-robin search: first pending line at or above rr_ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_idx = r_rr_ptr + ADDR_WIDTH'(i);
            if (!w_found && r_pending[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Load when enabled, output register free or draining, and work pending
    always_comb begin
        w_load      = enable && (!r_out_valid || out_ready) && (r_pending != '0);
        w_clear     = '0;
        if (w_load) begin
            w_clear[w_winner] = 1'b1;
        end
        w_spike_acc = enable ? spike_in : '0;
    end

    // Pending mask and pointer; a spike on the line being cleared survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_spike_acc;
            if (w_load) begin
                r_rr_ptr <= w_winner + ADDR_WIDTH'(1);
            end
        end
    end

    // Output register: holds while stalled, drops valid after an unreplaced transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_current <= '0;
            r_out_src     <= '0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_current <= r_weight[w_winner];
            r_out_src     <= w_winner;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_current = r_out_current;
    assign out_src     = r_out_src;
    assign pending_out = r_pending;

`ifdef SYN_DROP_CNT_EN
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    logic [N_INPUTS-1:0] w_drop_mask;
    logic [CNT_W-1:0]    w_drop_num;
    logic [8:0]          w_drop_sum;
    logic [7:0]          r_drop_count;

    // Spikes landing on a pending bit that is not being cleared are lost
    always_comb begin
        w_drop_mask = w_spike_acc & r_pending & ~w_clear;
        w_drop_num  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_drop_num = w_drop_num + CNT_W'(w_drop_mask[i]);
        end
        w_drop_sum  = {1'b0, r_drop_count} + 9'(w_drop_num);
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop_sum[8]) begin
            r_drop_count <= 8'hFF;
        end else begin
            r_drop_count <= w_drop_sum[7:0];
        end
    end

    assign drop_count = r_drop_count;
`else
    // Without the counter, merged spikes are silently absorbed by the OR above.
`endif

endmodule
`default_nettype wire

// File: tb/tb_synapse_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_synapse_driver
//  Purpose  : Directed self-checking bench for synapse_driver with an event
//             scoreboard and immediate-assertion comparisons.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_synapse_driver;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] spike_in;
    logic       w_we;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] out_current;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_src;
    logic [3:0] pending_out;
`ifdef SYN_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb [$];
    logic [7:0] tb_w [4];

    logic       hold_seen;
    logic [1:0] hold_src;
    logic [7:0] hold_cur;

    synapse_driver #(
        .N_INPUTS      (4),
        .ADDR_WIDTH    (2),
        .WEIGHT_WIDTH  (8),
        .DEFAULT_WEIGHT(8'h10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .spike_in    (spike_in),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .out_current (out_current),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src),
        .pending_out (pending_out)
`ifdef SYN_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        sb.push_back({2'(s), tb_w[s]});
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        w_we   = 1'b1;
        w_addr = 2'(a);
        w_data = d;
        tick();
        w_we   = 1'b0;
        tb_w[a] = d;
    endtask

    task automatic pulse(input logic [3:0] m);
        spike_in = m;
        tick();
        spike_in = 4'b0000;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);
        chk("drain_pending", 32'(pending_out), 32'd0);
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            hold_seen = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    chk("sb_event", 32'({out_src, out_current}), 32'(sb.pop_front()));
                end
            end
            if (out_valid && !out_ready) begin
                if (hold_seen) begin
                    chk("hold_src", 32'(out_src), 32'(hold_src));
                    chk("hold_cur", 32'(out_current), 32'(hold_cur));
                end
                hold_seen = 1'b1;
                hold_src  = out_src;
                hold_cur  = out_current;
            end else begin
                hold_seen = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; spike_in = '0; w_we = 1'b0;
        w_addr = '0; w_data = '0; out_ready = 1'b1; hold_seen = 1'b0;
        for (int i = 0; i < 4; i++) tb_w[i] = 8'h10;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pending", 32'(pending_out), 32'd0);
        chk("rst_current", 32'(out_current), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Idle with ready high
        repeat (3) tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_pending", 32'(pending_out), 32'd0);

        // Default weights read back through events
        push(0); push(1); push(2); push(3);
        pulse(4'b1111);
        wait_drain();

        // Disabled: spikes ignored
        enable = 1'b0;
        pulse(4'b0001);
        tick();
        chk("dis_pending", 32'(pending_out), 32'd0);
        chk("dis_valid", 32'(out_valid), 32'd0);
        enable = 1'b1;

        // Single event latency and programmed weight
        wr(2, 8'h25);
        push(2);
        pulse(4'b0100);
        chk("lat_pending", 32'(pending_out), 32'h4);
        chk("lat_valid_t1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid_t2", 32'(out_valid), 32'd1);
        chk("lat_current", 32'(out_current), 32'h25);
        chk("lat_src", 32'(out_src), 32'd2);
        tick();
        chk("lat_one_cycle", 32'(out_valid), 32'd0);

        // Distinct weights; move pointer back to 0 via line 3
        wr(0, 8'h01); wr(1, 8'h02); wr(3, 8'h04);
        push(3);
        pulse(4'b1000);
        wait_drain();

        // Round-robin burst 1011 from pointer 0
        push(0); push(1); push(3);
        pulse(4'b1011);
        chk("rr_pending", 32'(pending_out), 32'hB);
        tick();
        chk("rr_src0", 32'(out_src), 32'd0);
        tick();
        chk("rr_src1", 32'(out_src), 32'd1);
        tick();
        chk("rr_src3", 32'(out_src), 32'd3);
        chk("rr_valid3", 32'(out_valid), 32'd1);
        tick();
        chk("rr_done", 32'(out_valid), 32'd0);
        chk("rr_pend0", 32'(pending_out), 32'd0);

        // Pointer wrapped to 0: 0011 must come out 0 then 1
        push(0); push(1);
        pulse(4'b0011);
        wait_drain();

        // Backpressure: pointer at 2, lines 2 and 1 pending
        out_ready = 1'b0;
        push(2); push(1);
        pulse(4'b0110);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_src", 32'(out_src), 32'd2);
            chk("bp_cur", 32'(out_current), 32'h25);
            tick();
        end
        chk("bp_pending", 32'(pending_out), 32'h2);
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_src", 32'(out_src), 32'd1);
        chk("bp_next_cur", 32'(out_current), 32'h02);
        tick();
        chk("bp_end", 32'(out_valid), 32'd0);

        // Zero weight still issues an event
        wr(3, 8'h00);
        push(3);
        pulse(4'b1000);
        wait_drain();

        // Re-spike on the load edge keeps the new event
        push(1); push(1);
        spike_in = 4'b0010;
        tick();
        tick();
        spike_in = 4'b0000;
        chk("respike_valid", 32'(out_valid), 32'd1);
        chk("respike_pending", 32'(pending_out), 32'h2);
        tick();
        chk("respike_second", 32'(out_valid), 32'd1);
        chk("respike_src", 32'(out_src), 32'd1);
        wait_drain();
`ifdef SYN_DROP_CNT_EN
        chk("respike_nodrop", 32'(drop_count), 32'd0);
`endif

        // Merged spikes while output stalled
        out_ready = 1'b0;
        push(0);
        pulse(4'b0001);
        wait_valid();
        push(1);
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0010);
            tick();
        end
        chk("merge_pending", 32'(pending_out), 32'h2);
        chk("merge_src", 32'(out_src), 32'd0);
`ifdef SYN_DROP_CNT_EN
        chk("merge_drop", 32'(drop_count), 32'd2);
`endif
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with everything pending and output valid
        out_ready = 1'b0;
        pulse(4'b0001);
        wait_valid();
        pulse(4'b1111);
        chk("prerst_pending", 32'(pending_out), 32'hF);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pending", 32'(pending_out), 32'd0);
        chk("arst_src", 32'(out_src), 32'd0);
`ifdef SYN_DROP_CNT_EN
        chk("arst_drop", 32'(drop_count), 32'd0);
`endif
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tb_w[i] = 8'h10;
        push(0); push(1); push(2); push(3);
        pulse(4'b1111);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
